mw_display_monitor: RTL and testbench
=====================================

Name: mw_display_monitor

Overview:
- Observer for the microwave front panel's output side: receives the three seven-segment digit buses and `mag_on` from the controller.
- Decodes the glyphs back to BCD, filters display glitches, and tracks the cook state machine.
- Counts seconds of magnetron activity and flags protocol violations: bad glyphs, non-unit countdown steps, stalled countdown.
- Used in-system as a safety/self-check monitor and in benches as the scoreboard front end.

Parameters:
- TICKS_PER_SEC, 100, clock cycles per second (100 Hz panel clock).
- STABLE_CYCLES, 2, consecutive identical samples required before a display value is accepted (range 1..15).

Ports:
- clk  in  1  panel clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- sec_ones_seg  in  7  seconds-ones glyph.
- sec_tens_seg  in  7  seconds-tens glyph.
- min_segs  in  7  minutes glyph.
- mag_on  in  1  magnetron enable from the controller.
- min_bcd  out  4  accepted minutes digit.
- sec_tens_bcd  out  4  accepted seconds-tens digit.
- sec_ones_bcd  out  4  accepted seconds-ones digit.
- disp_valid  out  1  accepted value is valid.
- total_secs  out  10  accepted value in seconds: min*60 + tens*10 + ones, range 0..599.
- step_pulse  out  1  one cycle when an accepted value equals the previous one minus 1 while cooking.
- cook_done  out  1  one-cycle pulse: cook ended with display at 0.
- cook_abort  out  1  one-cycle pulse: cook ended with display nonzero (stop/door).
- mag_secs  out  10  whole seconds `mag_on` has been high in the current/last cook; saturates at 1023.
- err_glyph  out  1  sticky: invalid glyph accepted.
- err_step  out  1  sticky: bad countdown step.
- err_stall  out  1  sticky: no step within 2*TICKS_PER_SEC cycles while cooking.

Behaviour:
- Glyph encoding: bit6..bit0 = segments a..g, active-high.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - All-zero (blank) is legal on min_segs only and decodes to 0.
  - sec_tens legal values are 0..5. Any other pattern on any digit is invalid.
- Stability filter:
  - Raw triple compared each clock with the previous sample; a match counter resets to 1 on any change.
  - When the counter reaches STABLE_CYCLES, the triple is accepted. BCD outputs, total_secs and disp_valid update on that same edge.
  - A triple is accepted only once: the counter holds and there is no re-acceptance until the input changes.
  - Latency: new value first sampled at edge N is visible after edge N+STABLE_CYCLES-1.
- Invalid accepted triple: disp_valid=0, BCD/total_secs hold their last valid values, err_glyph set.
- mag_on is registered once (mag_q); the FSM uses mag_q.
- FSM states:
  - IDLE: on mag_q rising → COOK. Clear mag_secs, the tick counter and the stall counter; capture total_secs as prev.
  - COOK, each accepted valid value:
    - value == prev-1 → step_pulse, prev updated, stall counter cleared.
    - value == prev → no action.
    - any other value → err_step, prev updated.
  - COOK, stall counter reaching 2*TICKS_PER_SEC → err_stall, counter holds.
  - COOK, tick counter wrapping at TICKS_PER_SEC-1 → mag_secs +1, saturating at 1023.
  - COOK, on mag_q falling → IDLE. Pulse cook_done if prev==0, else cook_abort.
- Simultaneous events:
  - Acceptance and mag_q falling in the same cycle: the step check is evaluated first, then the done/abort decision uses the updated prev.
- Outside COOK: no step, stall or mag_secs activity; mag_secs holds.
- Sticky errors clear only on reset.
- Reset (any time, including mid-cook):
  - All BCD outputs 0, total_secs 0, disp_valid 0, mag_secs 0.
  - All pulses and errors 0, FSM in IDLE.
  - Filter counter 0 and previous sample 0, so the first post-reset sample counts as a change.

Test Plan:
- Reset, then hold glyphs 0/1/2 (min/tens/ones) → after STABLE_CYCLES: min_bcd=0, sec_tens_bcd=1, sec_ones_bcd=2, total_secs=12, disp_valid=1, no errors.
- Raise mag_on at 0:12, step the display 0:11…0:00 every 100 cycles, then drop mag_on → 12 step_pulses, mag_secs=12, cook_done once, no errors.
- Cook from 0:35, drop mag_on at 0:30 → cook_abort once, cook_done 0, mag_secs=5.
- During cook, jump the display from 1:29 to 1:27 → err_step=1, no step_pulse for that change. A one-cycle glitch to 8:88 with STABLE_CYCLES=2 → ignored, no err_glyph.
- Hold a sec_tens glyph of 7 → err_glyph=1, disp_valid=0, previous BCD held. Separately, freeze the display 200 cycles while mag_on=1 → err_stall=1.
- Assert resetn low mid-cook → all outputs 0 immediately (asynchronous). After release with mag_on still high: mag_q rises → COOK restarts with mag_secs counting from 0.

Source files
------------

// File: rtl/mw_display_monitor.sv
// Microwave front-panel output monitor: decodes the three seven-segment digits back to BCD.
// It debounces them, follows the cook cycle driven by mag_on and flags countdown protocol errors.
module mw_display_monitor #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] sec_ones_seg,
  input  logic [6:0] sec_tens_seg,
  input  logic [6:0] min_segs,
  input  logic       mag_on,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens_bcd,
  output logic [3:0] sec_ones_bcd,
  output logic       disp_valid,
  output logic [9:0] total_secs,
  output logic       step_pulse,
  output logic       cook_done,
  output logic       cook_abort,
  output logic [9:0] mag_secs,
  output logic       err_glyph,
  output logic       err_step,
  output logic       err_stall
);

  localparam int unsigned StallLimit = 2 * TICKS_PER_SEC;
  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SW = $clog2(StallLimit + 1);

  typedef enum logic [0:0] {StIdle, StCook} state_e;

  // Returns {valid, digit}.
  function automatic logic [4:0] seg_dec(input logic [6:0] seg);
    case (seg)
      7'b1111110: seg_dec = {1'b1, 4'd0};
      7'b0110000: seg_dec = {1'b1, 4'd1};
      7'b1101101: seg_dec = {1'b1, 4'd2};
      7'b1111001: seg_dec = {1'b1, 4'd3};
      7'b0110011: seg_dec = {1'b1, 4'd4};
      7'b1011011: seg_dec = {1'b1, 4'd5};
      7'b1011111: seg_dec = {1'b1, 4'd6};
      7'b1110000: seg_dec = {1'b1, 4'd7};
      7'b1111111: seg_dec = {1'b1, 4'd8};
      7'b1111011: seg_dec = {1'b1, 4'd9};
      default:    seg_dec = 5'd0;
    endcase
  endfunction

  logic [20:0]   raw, samp_q;
  logic [3:0]    cnt_q, cnt_d;
  logic          changed, accept;
  logic [4:0]    dm, dt, dn;
  logic          min_ok, tens_ok, ones_ok, acc_valid;
  logic [3:0]    min_v;
  logic [9:0]    new_total;
  logic [3:0]    min_q, tens_q, ones_q;
  logic [9:0]    total_q;
  logic          valid_q, err_glyph_q;

  assign raw = {min_segs, sec_tens_seg, sec_ones_seg};

  always_comb begin
    changed = (raw != samp_q);
    cnt_d   = cnt_q;
    if (changed) begin
      cnt_d = 4'd1;
    end else if (cnt_q < 4'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 4'd1;
    end
    // Fire only on the edge the count first reaches the threshold for this triple.
    accept = (cnt_d == 4'(STABLE_CYCLES)) && (changed || (cnt_q != 4'(STABLE_CYCLES)));
  end

  always_comb begin
    dm        = seg_dec(min_segs);
    dt        = seg_dec(sec_tens_seg);
    dn        = seg_dec(sec_ones_seg);
    min_ok    = dm[4] || (min_segs == 7'd0);
    min_v     = dm[4] ? dm[3:0] : 4'd0;
    tens_ok   = dt[4] && (dt[3:0] <= 4'd5);
    ones_ok   = dn[4];
    acc_valid = accept && min_ok && tens_ok && ones_ok;
    new_total = ({6'd0, min_v} * 10'd60) + ({6'd0, dt[3:0]} * 10'd10) + {6'd0, dn[3:0]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      samp_q      <= '0;
      cnt_q       <= '0;
      min_q       <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      total_q     <= '0;
      valid_q     <= 1'b0;
      err_glyph_q <= 1'b0;
    end else begin
      samp_q <= raw;
      cnt_q  <= cnt_d;
      if (acc_valid) begin
        min_q   <= min_v;
        tens_q  <= dt[3:0];
        ones_q  <= dn[3:0];
        total_q <= new_total;
        valid_q <= 1'b1;
      end else if (accept) begin
        valid_q     <= 1'b0;
        err_glyph_q <= 1'b1;
      end
    end
  end

  state_e        state_q, state_d;
  logic          mag_q;
  logic [9:0]    prev_q, prev_d, mag_secs_q, mag_secs_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          step_q, step_d, done_q, done_d, abort_q, abort_d;
  logic          err_step_q, err_step_d, err_stall_q, err_stall_d;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    mag_secs_d  = mag_secs_q;
    tick_d      = tick_q;
    stall_d     = stall_q;
    step_d      = 1'b0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    err_step_d  = err_step_q;
    err_stall_d = err_stall_q;
    unique case (state_q)
      StIdle: begin
        if (mag_q) begin
          state_d    = StCook;
          mag_secs_d = '0;
          tick_d     = '0;
          stall_d    = '0;
          prev_d     = total_q;
        end
      end
      StCook: begin
        if (acc_valid && (new_total == prev_q - 10'd1)) begin
          step_d  = 1'b1;
          prev_d  = new_total;
          stall_d = '0;
        end else begin
          if (acc_valid && (new_total != prev_q)) begin
            err_step_d = 1'b1;
            prev_d     = new_total;
          end
          if (stall_q != SW'(StallLimit)) stall_d = stall_q + 1'b1;
          if (stall_d == SW'(StallLimit)) err_stall_d = 1'b1;
        end
        if (mag_q) begin
          if (tick_q == TW'(TICKS_PER_SEC - 1)) begin
            tick_d = '0;
            if (mag_secs_q != 10'h3FF) mag_secs_d = mag_secs_q + 10'd1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end else begin
          // Decision uses prev after any same-cycle step check.
          state_d = StIdle;
          done_d  = (prev_d == 10'd0);
          abort_d = (prev_d != 10'd0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      mag_q       <= 1'b0;
      prev_q      <= '0;
      mag_secs_q  <= '0;
      tick_q      <= '0;
      stall_q     <= '0;
      step_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      err_step_q  <= 1'b0;
      err_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_on;
      prev_q      <= prev_d;
      mag_secs_q  <= mag_secs_d;
      tick_q      <= tick_d;
      stall_q     <= stall_d;
      step_q      <= step_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      err_step_q  <= err_step_d;
      err_stall_q <= err_stall_d;
    end
  end

  assign min_bcd      = min_q;
  assign sec_tens_bcd = tens_q;
  assign sec_ones_bcd = ones_q;
  assign disp_valid   = valid_q;
  assign total_secs   = total_q;
  assign step_pulse   = step_q;
  assign cook_done    = done_q;
  assign cook_abort   = abort_q;
  assign mag_secs     = mag_secs_q;
  assign err_glyph    = err_glyph_q;
  assign err_step     = err_step_q;
  assign err_stall    = err_stall_q;

endmodule

// File: tb/tb_mw_display_monitor.sv
// Directed bench for mw_display_monitor: decode table plus cook, error and reset sequences.
module tb_mw_display_monitor;

  localparam int unsigned S = 2;
  localparam int unsigned T = 100;

  logic       clk = 1'b0;
  logic       resetn;
  logic [6:0] sec_ones_seg, sec_tens_seg, min_segs;
  logic       mag_on;
  logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
  logic       disp_valid, step_pulse, cook_done, cook_abort;
  logic [9:0] total_secs, mag_secs;
  logic       err_glyph, err_step, err_stall;

  mw_display_monitor #(.TICKS_PER_SEC(T), .STABLE_CYCLES(S)) dut (
    .clk(clk), .resetn(resetn),
    .sec_ones_seg(sec_ones_seg), .sec_tens_seg(sec_tens_seg), .min_segs(min_segs),
    .mag_on(mag_on),
    .min_bcd(min_bcd), .sec_tens_bcd(sec_tens_bcd), .sec_ones_bcd(sec_ones_bcd),
    .disp_valid(disp_valid), .total_secs(total_secs),
    .step_pulse(step_pulse), .cook_done(cook_done), .cook_abort(cook_abort),
    .mag_secs(mag_secs),
    .err_glyph(err_glyph), .err_step(err_step), .err_stall(err_stall)
  );

  always #5 clk = ~clk;

  logic [6:0] lut [10];
  initial begin
    lut[0] = 7'b1111110; lut[1] = 7'b0110000; lut[2] = 7'b1101101; lut[3] = 7'b1111001;
    lut[4] = 7'b0110011; lut[5] = 7'b1011011; lut[6] = 7'b1011111; lut[7] = 7'b1110000;
    lut[8] = 7'b1111111; lut[9] = 7'b1111011;
  end

  int step_cnt = 0, done_cnt = 0, abort_cnt = 0;
  always @(negedge clk) begin
    if (step_pulse) step_cnt++;
    if (cook_done)  done_cnt++;
    if (cook_abort) abort_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m < 0 blanks the minutes digit.
  task automatic set_disp(input int m, input int t, input int o);
    min_segs     = (m < 0) ? 7'd0 : lut[m];
    sec_tens_seg = lut[t];
    sec_ones_seg = lut[o];
  endtask

  typedef struct {
    int m, t, o;
    int exp_min, exp_tens, exp_ones, exp_total;
  } vec_t;

  vec_t vecs [5];
  int s_step, s_done, s_abort;

  initial begin
    vecs[0] = '{m: 0,  t: 1, o: 2, exp_min: 0, exp_tens: 1, exp_ones: 2, exp_total: 12};
    vecs[1] = '{m: -1, t: 5, o: 9, exp_min: 0, exp_tens: 5, exp_ones: 9, exp_total: 59};
    vecs[2] = '{m: 9,  t: 5, o: 9, exp_min: 9, exp_tens: 5, exp_ones: 9, exp_total: 599};
    vecs[3] = '{m: 4,  t: 0, o: 8, exp_min: 4, exp_tens: 0, exp_ones: 8, exp_total: 248};
    vecs[4] = '{m: 5,  t: 0, o: 7, exp_min: 5, exp_tens: 0, exp_ones: 7, exp_total: 307};

    resetn = 1'b0;
    mag_on = 1'b0;
    set_disp(0, 1, 2);
    cyc(2);
    check("rst_total", total_secs, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_mag_secs", mag_secs, 0);
    check("rst_errs", {err_glyph, err_step, err_stall}, 0);
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      set_disp(vecs[i].m, vecs[i].t, vecs[i].o);
      cyc(S);
      check($sformatf("vec%0d_min", i), min_bcd, vecs[i].exp_min);
      check($sformatf("vec%0d_tens", i), sec_tens_bcd, vecs[i].exp_tens);
      check($sformatf("vec%0d_ones", i), sec_ones_bcd, vecs[i].exp_ones);
      check($sformatf("vec%0d_total", i), total_secs, vecs[i].exp_total);
      check($sformatf("vec%0d_valid", i), disp_valid, 1);
    end
    check("idle_errs", {err_glyph, err_step, err_stall}, 0);

    // Acceptance latency: not visible one edge early.
    set_disp(3, 4, 0);
    cyc(S - 1);
    check("lat_early", total_secs, 307);
    cyc(1);
    check("lat_ontime", total_secs, 220);

    // Full countdown 0:12 -> 0:00.
    set_disp(0, 1, 2);
    cyc(3);
    s_step = step_cnt; s_done = done_cnt; s_abort = abort_cnt;
    mag_on = 1'b1;
    for (int k = 11; k >= 0; k--) begin
      cyc(T);
      set_disp(0, k / 10, k % 10);
    end
    cyc(10);
    mag_on = 1'b0;
    cyc(3);
    check("c1_steps", step_cnt - s_step, 12);
    check("c1_mag_secs", mag_secs, 12);
    check("c1_done", done_cnt - s_done, 1);
    check("c1_abort", abort_cnt - s_abort, 0);
    check("c1_errs", {err_glyph, err_step, err_stall}, 0);

    // Aborted cook 0:35 -> 0:30.
    set_disp(0, 3, 5);
    cyc(3);
    s_step = step_cnt; s_done = done_cnt; s_abort = abort_cnt;
    mag_on = 1'b1;
    for (int k = 34; k >= 30; k--) begin
      cyc(T);
      set_disp(0, k / 10, k % 10);
    end
    cyc(10);
    mag_on = 1'b0;
    cyc(3);
    check("c2_abort", abort_cnt - s_abort, 1);
    check("c2_done", done_cnt - s_done, 0);
    check("c2_mag_secs", mag_secs, 5);
    check("c2_steps", step_cnt - s_step, 5);

    // Skipped second, then a one-cycle glitch.
    set_disp(1, 2, 9);
    cyc(3);
    s_step = step_cnt; s_abort = abort_cnt;
    mag_on = 1'b1;
    cyc(50);
    set_disp(1, 2, 7);
    cyc(5);
    check("skip_err_step", err_step, 1);
    check("skip_no_step", step_cnt - s_step, 0);
    set_disp(8, 8, 8);
    cyc(1);
    set_disp(1, 2, 7);
    cyc(5);
    check("glitch_err_glyph", err_glyph, 0);
    check("glitch_valid", disp_valid, 1);
    check("glitch_total", total_secs, 87);
    mag_on = 1'b0;
    cyc(3);
    check("c3_abort", abort_cnt - s_abort, 1);

    // Illegal seconds-tens glyph (7).
    set_disp(0, 7, 3);
    cyc(3);
    check("bad_err_glyph", err_glyph, 1);
    check("bad_valid", disp_valid, 0);
    check("bad_hold_bcd", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 12'h127);
    check("bad_hold_total", total_secs, 87);

    // Frozen display during cook.
    set_disp(2, 0, 0);
    cyc(3);
    check("st_valid", disp_valid, 1);
    mag_on = 1'b1;
    cyc(150);
    check("st_not_yet", err_stall, 0);
    cyc(60);
    check("st_err_stall", err_stall, 1);
    check("st_mag_secs", mag_secs, 2);

    // Asynchronous reset mid-cook, mag_on kept high.
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("ar_total", total_secs, 0);
    check("ar_bcd", {min_bcd, sec_tens_bcd, sec_ones_bcd}, 0);
    check("ar_valid", disp_valid, 0);
    check("ar_mag_secs", mag_secs, 0);
    check("ar_errs", {err_glyph, err_step, err_stall}, 0);
    cyc(2);
    resetn = 1'b1;
    cyc(150);
    check("rc_mag_secs", mag_secs, 1);
    check("rc_total", total_secs, 120);
    check("rc_errs", {err_glyph, err_step, err_stall}, 0);
    mag_on = 1'b0;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
